noc_buffer_out: RTL and testbench
=================================

// Module: noc_buffer_out
// PURPOSE
//   Store-and-forward transmit buffer between tile-side packet producer and the NoC egress link.
//   Accepts AXI-stream beats into a single-clock FIFO and counts the complete packets (TLAST) stored.
//   Launches a packet onto the NoC only once it is fully buffered, so the link never stalls mid-packet
//   on a slow source. Optional cut-through fallback prevents deadlock on packets longer than the FIFO.
// PARAMETERS
//   ADDR_W          6   FIFO depth = 1<<ADDR_W beats; each beat 37b = {TLAST,TKEEP[3:0],TDATA[31:0]}
//   CUT_THROUGH_EN  1   1: when FIFO full with no complete packet stored, start sending anyway
// PORTS
//   clk_in             in   1        single clock for the whole block
//   clk_in_rst_low     in   1        reset, synchronous, active-low
//   stream_in_TVALID   in   1        tile-side beat valid
//   stream_in_TDATA    in   32       tile-side data
//   stream_in_TKEEP    in   4        tile-side byte keep
//   stream_in_TLAST    in   1        last beat of packet
//   stream_in_TREADY   out  1        buffer can accept a beat
//   stream_out_TVALID  out  1        NoC-side beat valid
//   stream_out_TDATA   out  32       NoC-side data
//   stream_out_TKEEP   out  4        NoC-side byte keep
//   stream_out_TLAST   out  1        last beat of packet
//   stream_out_TREADY  in   1        NoC accepts beat
//   pkt_count          out  ADDR_W+1 complete packets stored and not yet fully sent
//   fifo_level         out  ADDR_W+1 beats currently in FIFO (excludes the output register)
// BEHAVIOUR
//   Reset (clk_in_rst_low=0 at posedge): pointers, level, pkt_count, FSM and output reg cleared.
//     stream_out_TVALID/TDATA/TKEEP/TLAST=0. stream_in_TREADY=0 while reset low; partial packets dropped.
//   Pointers: wr_ptr/rd_ptr ADDR_W+1 bits, natural wrap; level = wr_ptr - rd_ptr; full when level==1<<ADDR_W.
//   stream_in_TREADY = ~full, decoded from registered state only (no path from stream_in_TVALID).
//   Write on stream_in_TVALID & stream_in_TREADY. The full FIFO never accepts, so there is no overflow.
//   pkt_count: +1 on accepted input beat with TLAST; -1 on output handshake with TLAST; both -> unchanged.
//   Output register holds the beat presented on stream_out_*. It loads via a synchronous read of mem[rd_ptr].
//     Each load increments rd_ptr and decrements level.
//   Handshake: once stream_out_TVALID=1, data/keep/last stay stable until stream_out_TREADY=1.
//   FSM IDLE:
//     if (pkt_count!=0) | (CUT_THROUGH_EN & full & pkt_count==0): load beat, set valid next cycle, -> SEND.
//   FSM SEND:
//     on handshake with TLAST=1: valid->0, -> IDLE. There is one mandatory idle cycle between packets.
//     on handshake with TLAST=0 and level!=0: load next beat, so valid stays 1 (back-to-back beats).
//     on handshake with TLAST=0 and level==0: valid->0, stay SEND (cut-through underrun only).
//       Load when level!=0.
//     in SEND with valid=0 and level!=0: load next beat.
//   Latency: input TLAST beat accepted at edge N on empty buffer -> pkt_count=1 after N -> beat loaded at N+1.
//     stream_out_TVALID=1 after edge N+1. Minimum 2 cycles input-to-output.
//   Throughput: 1 beat/cycle within a packet when stream_out_TREADY=1. Input and output are independent;
//     simultaneous write and read at any level are legal.
//   pkt_count never exceeds 1<<ADDR_W. Underflow is impossible in normal mode.
//     In cut-through, the TLAST of a forced packet is counted on entry, so -1 on exit balances it.
// TESTING
//   1 Reset, then a single beat TDATA=0xA5A5_0001 TKEEP=F TLAST=1 with out READY=1.
//     -> stream_out_TVALID high 2 cycles later with identical fields, for 1 cycle. pkt_count 0->1->0.
//   2 4-beat packet, input TVALID gaps, TLAST on beat 4, out READY=1.
//     -> no out VALID until beat 4 accepted; then 4 consecutive beats, data 0x10..0x13 in order.
//   3 Out READY=0 for 10 cycles on beat 2 of 4.
//     -> VALID stays 1, TDATA=0x11 stable. Resumes 0x12,0x13 once READY=1.
//   4 ADDR_W=4, 16 beats without TLAST, out READY=0.
//     -> TREADY in=0 at level 16. With CUT_THROUGH_EN=1, out VALID=1.
//     Then READY=1 plus 4 more beats ending in TLAST -> all 20 beats delivered, VALID drops on underrun.
//   5 Input TLAST accepted in same cycle as output TLAST handshake, pkt_count=2 -> pkt_count stays 2.
//   6 Reset asserted mid-packet (beat 2 of 4 on output) -> next cycle all outputs 0, pkt_count=0, level=0.
//     A subsequent 1-beat packet is sent correctly.

Source files
------------

// File: rtl/noc_buffer_out.sv
// Store-and-forward egress buffer: AXI-stream beats are queued in a single-clock FIFO and a packet
// is launched onto the NoC only once its TLAST beat is stored (with an optional cut-through escape).
module noc_buffer_out #(
  parameter int ADDR_W         = 6,
  parameter bit CUT_THROUGH_EN = 1'b1
) (
  input  logic              clk_in,
  input  logic              clk_in_rst_low,
  input  logic              stream_in_TVALID,
  input  logic [31:0]       stream_in_TDATA,
  input  logic [3:0]        stream_in_TKEEP,
  input  logic              stream_in_TLAST,
  output logic              stream_in_TREADY,
  output logic              stream_out_TVALID,
  output logic [31:0]       stream_out_TDATA,
  output logic [3:0]        stream_out_TKEEP,
  output logic              stream_out_TLAST,
  input  logic              stream_out_TREADY,
  output logic [ADDR_W:0]   pkt_count,
  output logic [ADDR_W:0]   fifo_level
);

  localparam int BEAT_W = 37;
  localparam logic [ADDR_W:0] FULL_LEVEL = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE        = {{ADDR_W{1'b0}}, 1'b1};

  typedef enum logic {IDLE, SEND} state_t;

  logic [BEAT_W-1:0] mem [0:(1<<ADDR_W)-1];

  logic [ADDR_W:0]   wr_ptr_reg;
  logic [ADDR_W:0]   rd_ptr_reg;
  logic [ADDR_W:0]   pkt_count_reg;
  logic [ADDR_W:0]   level;
  logic [BEAT_W-1:0] beat_reg;
  logic              valid_reg;
  logic              valid_next;
  state_t            state_reg;
  state_t            state_next;

  logic full;
  logic in_ready;
  logic wr_en;
  logic in_last_acc;
  logic hs;
  logic hs_last;
  logic load;

  assign level       = wr_ptr_reg - rd_ptr_reg;
  assign full        = (level == FULL_LEVEL);
  // Ready depends only on registered occupancy and reset, never on the producer's valid.
  assign in_ready    = clk_in_rst_low & ~full;
  assign wr_en       = stream_in_TVALID & in_ready;
  assign in_last_acc = wr_en & stream_in_TLAST;
  assign hs          = valid_reg & stream_out_TREADY;
  assign hs_last     = hs & beat_reg[BEAT_W-1];

  always_comb begin
    state_next = state_reg;
    valid_next = valid_reg;
    load       = 1'b0;
    case (state_reg)
      IDLE: begin
        // Start a packet when one is complete, or force one out of a full FIFO to avoid deadlock.
        if ((level != '0) &&
            ((pkt_count_reg != '0) || (CUT_THROUGH_EN && full && (pkt_count_reg == '0)))) begin
          load       = 1'b1;
          valid_next = 1'b1;
          state_next = SEND;
        end
      end
      SEND: begin
        if (hs) begin
          if (beat_reg[BEAT_W-1]) begin
            valid_next = 1'b0;
            state_next = IDLE;
          end else if (level != '0) begin
            load       = 1'b1;
            valid_next = 1'b1;
          end else begin
            valid_next = 1'b0;
          end
        end else if (!valid_reg && (level != '0)) begin
          load       = 1'b1;
          valid_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (wr_en) begin
      mem[wr_ptr_reg[ADDR_W-1:0]] <= {stream_in_TLAST, stream_in_TKEEP, stream_in_TDATA};
    end
  end

  always_ff @(posedge clk_in) begin
    if (!clk_in_rst_low) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      pkt_count_reg <= '0;
      beat_reg      <= '0;
      valid_reg     <= 1'b0;
      state_reg     <= IDLE;
    end else begin
      if (wr_en) begin
        wr_ptr_reg <= wr_ptr_reg + ONE;
      end
      if (load) begin
        rd_ptr_reg <= rd_ptr_reg + ONE;
        beat_reg   <= mem[rd_ptr_reg[ADDR_W-1:0]];
      end
      case ({in_last_acc, hs_last})
        2'b10:   pkt_count_reg <= pkt_count_reg + ONE;
        2'b01:   pkt_count_reg <= pkt_count_reg - ONE;
        default: pkt_count_reg <= pkt_count_reg;
      endcase
      valid_reg <= valid_next;
      state_reg <= state_next;
    end
  end

  assign stream_in_TREADY  = in_ready;
  assign stream_out_TVALID = valid_reg;
  assign stream_out_TDATA  = beat_reg[31:0];
  assign stream_out_TKEEP  = beat_reg[35:32];
  assign stream_out_TLAST  = beat_reg[36];
  assign pkt_count         = pkt_count_reg;
  assign fifo_level        = level;

endmodule

// File: tb/tb_noc_buffer_out.sv
// Bench for noc_buffer_out (depth 16, cut-through on): directed scenarios plus random packets,
// with a queue of accepted beats that a negedge monitor drains against the NoC-side output.
module tb_noc_buffer_out;

  localparam int ADDR_W = 4;
  localparam logic [ADDR_W:0] DEPTH_L = 5'd16;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_data;
  logic [3:0]  in_keep;
  logic        in_last;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic [3:0]  out_keep;
  logic        out_last;
  logic        out_ready;
  logic [ADDR_W:0] pkt_count;
  logic [ADDR_W:0] fifo_level;

  int checks = 0;
  int errors = 0;
  int beats_out = 0;
  logic [36:0] exp_q[$];
  logic forced_ok = 1'b0;
  logic rand_rdy  = 1'b0;

  noc_buffer_out #(.ADDR_W(ADDR_W), .CUT_THROUGH_EN(1'b1)) dut (
    .clk_in            (clk),
    .clk_in_rst_low    (rst_n),
    .stream_in_TVALID  (in_valid),
    .stream_in_TDATA   (in_data),
    .stream_in_TKEEP   (in_keep),
    .stream_in_TLAST   (in_last),
    .stream_in_TREADY  (in_ready),
    .stream_out_TVALID (out_valid),
    .stream_out_TDATA  (out_data),
    .stream_out_TKEEP  (out_keep),
    .stream_out_TLAST  (out_last),
    .stream_out_TREADY (out_ready),
    .pkt_count         (pkt_count),
    .fifo_level        (fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called just after a posedge; returns just after the accepting posedge.
  task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    int t;
    logic ok;
    t = 0;
    ok = 1'b0;
    in_valid = 1'b1; in_data = d; in_keep = k; in_last = l;
    while (t < 2000) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
      t++;
    end
    chk("in_accept_timeout", ok, 1'b1);
    @(posedge clk);
    if (ok) exp_q.push_back({l, k, d});
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_drain(input string name);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || out_valid) && t < 1000) begin
      @(posedge clk); #1; t++;
    end
    chk(name, t < 1000, 1'b1);
  endtask

  // Monitor: model of pkt_count is the number of TLAST beats accepted but not yet handed off.
  int          mon_tl;
  logic        stall_prev = 1'b0;
  logic        last_hs_prev = 1'b0;
  logic [36:0] stall_beat;
  logic [36:0] cur_beat;
  logic [36:0] exp_beat;

  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev   = 1'b0;
      last_hs_prev = 1'b0;
    end else begin
      cur_beat = {out_last, out_keep, out_data};
      mon_tl = 0;
      foreach (exp_q[i]) if (exp_q[i][36]) mon_tl++;
      chk("pkt_count", pkt_count, mon_tl);
      chk("in_ready_vs_full", in_ready, fifo_level != DEPTH_L);
      if (last_hs_prev) chk("idle_gap_valid", out_valid, 1'b0);
      if (stall_prev) begin
        chk("hold_valid", out_valid, 1'b1);
        chk("hold_beat", cur_beat, stall_beat);
      end
      if (out_valid && !forced_ok) chk("early_valid", mon_tl != 0, 1'b1);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", cur_beat, 37'h0_0000_0000);
        end else begin
          exp_beat = exp_q.pop_front();
          beats_out++;
          $display("out beat %0d: data=%h keep=%h last=%b (expected %h %h %b)", beats_out,
                   out_data, out_keep, out_last, exp_beat[31:0], exp_beat[35:32], exp_beat[36]);
          chk("out_beat", cur_beat, exp_beat);
        end
      end
      stall_prev   = out_valid && !out_ready;
      stall_beat   = cur_beat;
      last_hs_prev = out_valid && out_ready && out_last;
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic found;
    int   len;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_keep = '0; in_last = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", {out_last, out_keep, out_data}, 37'h0);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_pkt_count", pkt_count, 0);
    chk("rst_level", fifo_level, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    idle_cycles(2);

    // 1: single-beat packet, two-cycle latency, one cycle of valid
    send_beat(32'hA5A5_0001, 4'hF, 1'b1);
    @(negedge clk);
    chk("t1_valid_n", out_valid, 1'b0);
    chk("t1_pkt_n", pkt_count, 1);
    @(negedge clk);
    chk("t1_valid_n1", out_valid, 1'b1);
    chk("t1_beat", {out_last, out_keep, out_data}, {1'b1, 4'hF, 32'hA5A5_0001});
    @(negedge clk);
    chk("t1_valid_n2", out_valid, 1'b0);
    chk("t1_pkt_n2", pkt_count, 0);
    @(posedge clk); #1;

    // 2: 4-beat packet with input gaps; nothing leaves until TLAST is stored
    for (int i = 0; i < 3; i++) begin
      send_beat(32'h10 + i, 4'hF, 1'b0);
      idle_cycles(2);
    end
    @(negedge clk);
    chk("t2_no_early", out_valid, 1'b0);
    @(posedge clk); #1;
    send_beat(32'h13, 4'hF, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    chk("t2_first_valid", out_valid, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t2_b2b", out_valid, 1'b1);
    end
    @(posedge clk); #1;
    wait_drain("t2_drain");

    // 3: backpressure on beat 2 for 10 cycles
    for (int i = 0; i < 4; i++) send_beat(32'h10 + i, 4'h3, i == 3);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (out_valid && out_data == 32'h11) begin found = 1'b1; break; end
    end
    chk("t3_found_beat2", found, 1'b1);
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t3_stall", {out_valid, out_data}, {1'b1, 32'h11});
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_drain("t3_drain");

    // 4: FIFO fills with an unterminated packet; cut-through launches it
    forced_ok = 1'b1;
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) send_beat(32'h100 + i, 4'hF, 1'b0);
    @(negedge clk);
    chk("t4_level_full", fifo_level, 16);
    chk("t4_in_ready_full", in_ready, 1'b0);
    chk("t4_valid_before", out_valid, 1'b0);
    @(negedge clk);
    chk("t4_forced_valid", out_valid, 1'b1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (fifo_level == 0 && !out_valid) break;
    end
    chk("t4_underrun_level", fifo_level, 0);
    chk("t4_underrun_valid", out_valid, 1'b0);
    chk("t4_underrun_pkt", pkt_count, 0);
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      send_beat(32'h110 + i, 4'hF, i == 3);
      idle_cycles(1);
    end
    wait_drain("t4_drain");
    forced_ok = 1'b0;

    // 5: simultaneous input TLAST and output TLAST with two packets stored
    out_ready = 1'b0;
    send_beat(32'h501, 4'hF, 1'b1);
    send_beat(32'h502, 4'hF, 1'b1);
    idle_cycles(3);
    chk("t5_pre_valid", out_valid, 1'b1);
    chk("t5_pre_pkt", pkt_count, 2);
    out_ready = 1'b1;
    send_beat(32'h503, 4'hF, 1'b1);
    @(negedge clk);
    chk("t5_pkt_same", pkt_count, 2);
    @(posedge clk); #1;
    wait_drain("t5_drain");

    // 6: reset while beat 2 of 4 is on the output
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_beat(32'h20 + i, 4'hF, i == 3);
    for (int i = 0; i < 10; i++) begin
      if (out_valid) break;
      @(posedge clk); #1;
    end
    chk("t6_valid", out_valid, 1'b1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("t6_beat2", out_data, 32'h21);
    rst_n = 1'b0;
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    chk("t6_rst_valid", out_valid, 1'b0);
    chk("t6_rst_beat", {out_last, out_keep, out_data}, 37'h0);
    chk("t6_rst_pkt", pkt_count, 0);
    chk("t6_rst_level", fifo_level, 0);
    chk("t6_rst_in_ready", in_ready, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    send_beat(32'hCAFE_0006, 4'h1, 1'b1);
    wait_drain("t6_drain");

    // Random packets (up to 8 beats) with random gaps and output backpressure
    rand_rdy = 1'b1;
    for (int p = 0; p < 30; p++) begin
      len = $urandom_range(1, 8);
      for (int b = 0; b < len; b++) begin
        send_beat($urandom, 4'($urandom_range(1, 15)), b == len - 1);
        idle_cycles($urandom_range(0, 2));
      end
    end
    rand_rdy = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_drain("rand_drain");
    @(negedge clk);
    chk("final_pkt", pkt_count, 0);
    chk("final_level", fifo_level, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
